// File: rtl/fpu_seq_pkg.sv
// Shared encodings for the EX-stage FP sequencer: op codes, default unit
// latencies and the sequencer state encoding.
package fpu_seq_pkg;

  typedef enum logic [2:0] {
    FOP_ITOF    = 3'b000,
    FOP_FTOI    = 3'b001,
    FOP_FNEG    = 3'b010,
    FOP_FADD    = 3'b011,
    FOP_FSUB    = 3'b100,
    FOP_FMUL    = 3'b101,
    FOP_FDIV    = 3'b110,
    FOP_ILLEGAL = 3'b111
  } fop_e;

  localparam int LAT_ADDSUB_DEF = 7;
  localparam int LAT_MUL_DEF    = 5;
  localparam int LAT_DIV_DEF    = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  // Zero latency marks ops resolved inside the sequencer itself.
  function automatic logic [3:0] fop_latency(input fop_e op, input logic [3:0] lat_as,
                                             input logic [3:0] lat_mul, input logic [3:0] lat_div);
    case (op)
      FOP_FADD, FOP_FSUB: fop_latency = lat_as;
      FOP_FMUL:           fop_latency = lat_mul;
      FOP_FDIV:           fop_latency = lat_div;
      default:            fop_latency = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/fp_latency_counter.sv
// Down-counter tracking the fixed latency of the active FP unit; expire
// marks the last cycle of the operation (count == 1).
module fp_latency_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_flush,
  output logic       o_expire
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_cnt <= 4'd0;
    else if (i_flush)        r_cnt <= 4'd0;
    else if (i_load)         r_cnt <= i_load_val;
    else if (r_cnt != 4'd0)  r_cnt <= r_cnt - 4'd1;
  end

  assign o_expire = (r_cnt == 4'd1);

endmodule

// File: rtl/fpu_sequencer.sv
// EX-stage sequencer for the multi-cycle FP units: holds operands, stalls the
// pipeline for the unit latency and registers the selected result.
module fpu_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int LAT_ADDSUB = LAT_ADDSUB_DEF,
  parameter int LAT_MUL    = LAT_MUL_DEF,
  parameter int LAT_DIV    = LAT_DIV_DEF,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [2:0]       issue_op,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [31:0]      src_a,
  input  logic [31:0]      src_b,
  input  logic             flush,
  input  logic [31:0]      addsub_result,
  input  logic [31:0]      mul_result,
  input  logic [31:0]      div_result,
  input  logic             div_by_zero,
  output logic [31:0]      unit_a,
  output logic [31:0]      unit_b,
  output logic             add_sub,
  output logic             busy,
  output logic [31:0]      result,
  output logic             result_valid,
  output logic [TAG_W-1:0] result_tag,
  output logic             result_dbz,
  output logic             illegal_op
);

  seq_state_e       r_state, w_next;
  fop_e             r_op;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_a, r_b;
  logic             r_add_sub;

  fop_e        w_op;
  logic [3:0]  w_lat;
  logic        w_accept, w_multi, w_expire, w_done;
  logic [31:0] w_unit_res;

  assign w_op     = fop_e'(issue_op);
  assign w_lat    = fop_latency(w_op, 4'(LAT_ADDSUB), 4'(LAT_MUL), 4'(LAT_DIV));
  assign w_multi  = (w_lat != 4'd0);
  assign w_accept = (r_state == ST_IDLE) & issue_valid & ~flush;
  // A flush landing on the capture cycle still kills the result.
  assign w_done   = (r_state == ST_RUN) & w_expire & ~flush;

  fp_latency_counter u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept & w_multi),
    .i_load_val (w_lat),
    .i_flush    (flush),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_multi) w_next = ST_RUN;
      ST_RUN:  if (flush || w_expire)   w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= FOP_ITOF;
      r_tag     <= '0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_add_sub <= 1'b1;
    end else if (w_accept) begin
      r_op      <= w_op;
      r_tag     <= issue_tag;
      r_a       <= src_a;
      r_b       <= src_b;
      r_add_sub <= (w_op != FOP_FSUB);
    end
  end

  always_comb begin
    w_unit_res = 32'd0;
    case (r_op)
      FOP_FADD, FOP_FSUB: w_unit_res = addsub_result;
      FOP_FMUL:           w_unit_res = mul_result;
      FOP_FDIV:           w_unit_res = div_result;
      default:            w_unit_res = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= 32'd0;
      result_valid <= 1'b0;
      result_tag   <= '0;
      result_dbz   <= 1'b0;
      illegal_op   <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (w_accept && !w_multi) begin
        result       <= (w_op == FOP_FNEG) ? {~src_a[31], src_a[30:0]} : 32'd0;
        result_valid <= 1'b1;
        result_tag   <= issue_tag;
        result_dbz   <= 1'b0;
        illegal_op   <= (w_op != FOP_FNEG);
      end else if (w_done) begin
        result       <= w_unit_res;
        result_valid <= 1'b1;
        result_tag   <= r_tag;
        result_dbz   <= (r_op == FOP_FDIV) & div_by_zero;
        illegal_op   <= 1'b0;
      end
    end
  end

  // Idle: operands pass straight through so the units start in cycle 0.
  assign unit_a  = (r_state == ST_RUN) ? r_a : src_a;
  assign unit_b  = (r_state == ST_RUN) ? r_b : src_b;
  assign add_sub = (r_state == ST_RUN) ? r_add_sub : (w_op != FOP_FSUB);
  assign busy    = ~rst & ((r_state == ST_RUN) | w_accept);

endmodule
